tx_serializer: RTL and testbench
================================

TX_SERIALIZER -- requirements
Module: tx_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, word width in bits.
REQ-002 SHALL have parameter N_WORDS, default 4, words per transfer; ADR_W = clog2(N_WORDS) = 2.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port clr  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  begin transfer, sampled in IDLE or DONE only.
REQ-006 SHALL have port Rx_ready  input  1  receiver ready for a word.
REQ-007 SHALL have port rd_data  input  DATA_W  memory read data, valid the cycle after rd_en.
REQ-008 SHALL have port rd_en  output  1  memory read strobe.
REQ-009 SHALL have port adr  output  ADR_W  memory word address.
REQ-010 SHALL have port Tx_vld  output  1  word offered to receiver.
REQ-011 SHALL have port Tx_data  output  1  serial data bit.
REQ-012 SHALL have port Tx_busy  output  1  transfer in progress.
REQ-013 SHALL have port Tx_finish  output  1  all N_WORDS sent.

Function
REQ-014 SHALL implement states IDLE, READ, LATCH, VALID, SHIFT, NEXT, DONE; outputs decoded from state (Moore), Tx_data from shift register.
REQ-015 IDLE: start=1 -> READ, adr <= 0; else stay.
REQ-016 READ: rd_en=1 for exactly one cycle; -> LATCH.
REQ-017 LATCH: shift register <= rd_data at the closing edge; -> VALID.
REQ-018 VALID: Tx_vld=1, Tx_data=0; handshake edge = edge with Rx_ready=1 -> SHIFT, bit counter <= 0; Rx_ready=0 -> stay, indefinitely.
REQ-019 SHIFT: Tx_vld=0, Tx_data = shift register bit 0 (LSB first); each edge shift right, counter +1; edge at counter=DATA_W-1 -> NEXT; lasts exactly DATA_W cycles.
REQ-020 Bit i SHALL appear on Tx_data during cycle i after the handshake edge (i=0..DATA_W-1), for sampling at handshake edge + i+1.
REQ-021 NEXT: adr=N_WORDS-1 -> DONE; else adr <= adr+1, -> READ; adr never wraps within a transfer.
REQ-022 DONE: Tx_finish=1, held; start=1 -> READ with adr <= 0.
REQ-023 Tx_busy=1 in READ, LATCH, VALID, SHIFT, NEXT; 0 in IDLE, DONE.
REQ-024 start outside IDLE/DONE SHALL be ignored; Rx_ready outside VALID SHALL be ignored.
REQ-025 Per-word latency with Rx_ready=1: start edge to Tx_vld high = 2 cycles; word period = 12 cycles (READ 1, LATCH 1, VALID 1, SHIFT 8, NEXT 1).
REQ-026 Tx_data SHALL be 0 in every state except SHIFT.

Reset
REQ-027 clr=1 SHALL force IDLE immediately, independent of clk, from any state including mid-SHIFT.
REQ-028 Reset values: adr=0, rd_en=0, Tx_vld=0, Tx_data=0, Tx_busy=0, Tx_finish=0, shift register=0, bit counter=0.
REQ-029 After clr deasserts, no transfer SHALL start without a fresh start pulse.

Structure
REQ-030 State encodings, DATA_W and N_WORDS defaults SHALL live in a shared package reused by the receiver side.
REQ-031 Datapath (shift register + bit counter) SHALL be one sub-module, tx_shift_reg; FSM and address counter stay in tx_serializer.

Verification
REQ-032 Reset: clr pulse mid-run -> all outputs 0 same cycle, IDLE, adr=0.
REQ-033 Memory {A5,3C,FF,00}, Rx_ready=1, start pulse -> Tx_vld 2 cycles after start, A5 bits 1,0,1,0,0,1,0,1; four 12-cycle words; Tx_finish=1 after 48 cycles, adr=3.
REQ-034 Rx_ready=0 for 5 cycles in VALID -> Tx_vld held 6 cycles, Tx_data=0, shift register unchanged, then normal 8-bit shift.
REQ-035 clr=1 at bit 4 of word 2 -> immediate IDLE, Tx_busy=0; subsequent start resends from adr=0.
REQ-036 start pulsed during SHIFT -> no effect; start in DONE -> Tx_finish=0 next cycle, restart at adr=0.
REQ-037 Rx_ready toggled during SHIFT -> bit sequence and timing unchanged.

Source files
------------

// File: rtl/tx_serializer_pkg.sv
// Shared definitions for the serial link transmitter and its receiver.
package tx_serializer_pkg;

  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned N_WORDS_DEF = 4;

  // Encodings are shared with the receiver side; keep values stable.
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRead  = 3'd1,
    StLatch = 3'd2,
    StValid = 3'd3,
    StShift = 3'd4,
    StNext  = 3'd5,
    StDone  = 3'd6
  } tx_state_e;

  // A transfer is in flight in every state except the two resting ones.
  function automatic logic state_is_busy(input tx_state_e s);
    return (s != StIdle) && (s != StDone);
  endfunction

endpackage

// File: rtl/tx_shift_reg.sv
// Transmit datapath: parallel-load shift register (LSB out first) and bit counter.
module tx_shift_reg
  import tx_serializer_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  logic              start_shift,
  input  logic              shift,
  output logic              lsb,
  output logic              last
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] sreg_q;
  logic [CNT_W-1:0]  cnt_q;

  // Shift register: load a fresh word, or shift right with zero fill.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sreg_q <= '0;
    end else if (load) begin
      sreg_q <= din;
    end else if (shift) begin
      sreg_q <= sreg_q >> 1;
    end
  end

  // Bit counter: zeroed on the handshake edge, advances once per shifted bit.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q <= '0;
    end else if (start_shift) begin
      cnt_q <= '0;
    end else if (shift) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign lsb  = sreg_q[0];
  assign last = (cnt_q == CNT_LAST);

endmodule

// File: rtl/tx_serializer.sv
// Reads N_WORDS words from memory and sends each bit-serially after a
// valid/ready handshake with the receiver.
module tx_serializer
  import tx_serializer_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned N_WORDS = N_WORDS_DEF,
  localparam int unsigned ADR_W  = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              Rx_ready,
  input  logic [DATA_W-1:0] rd_data,
  output logic              rd_en,
  output logic [ADR_W-1:0]  adr,
  output logic              Tx_vld,
  output logic              Tx_data,
  output logic              Tx_busy,
  output logic              Tx_finish
);

  localparam logic [ADR_W-1:0] ADR_LAST = ADR_W'(N_WORDS - 1);

  tx_state_e state_q, state_d;
  logic      shift_q;
  logic      lsb;
  logic      last;
  logic      resting;

  assign resting = (state_q == StIdle) || (state_q == StDone);

  // Next-state decode; start and Rx_ready only matter in their own states.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle,
      StDone:  if (start) state_d = StRead;
      StRead:  state_d = StLatch;
      StLatch: state_d = StValid;
      StValid: if (Rx_ready) state_d = StShift;
      StShift: if (last) state_d = StNext;
      StNext:  state_d = (adr == ADR_LAST) ? StDone : StRead;
      default: state_d = StIdle;
    endcase
  end

  // State register with outputs registered from the next state, so each
  // output is a clean flop that tracks the state it belongs to.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= StIdle;
      rd_en     <= 1'b0;
      Tx_vld    <= 1'b0;
      Tx_busy   <= 1'b0;
      Tx_finish <= 1'b0;
      shift_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_en     <= (state_d == StRead);
      Tx_vld    <= (state_d == StValid);
      Tx_busy   <= state_is_busy(state_d);
      Tx_finish <= (state_d == StDone);
      shift_q   <= (state_d == StShift);
    end
  end

  // Word address: cleared on a new transfer, advanced between words, never wraps.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      adr <= '0;
    end else if (resting && start) begin
      adr <= '0;
    end else if ((state_q == StNext) && (adr != ADR_LAST)) begin
      adr <= adr + 1'b1;
    end
  end

  tx_shift_reg #(
    .DATA_W (DATA_W)
  ) u_shift (
    .clk         (clk),
    .clr         (clr),
    .load        (state_q == StLatch),
    .din         (rd_data),
    .start_shift ((state_q == StValid) && Rx_ready),
    .shift       (state_q == StShift),
    .lsb         (lsb),
    .last        (last)
  );

  // Serial line idles low outside the shift phase.
  assign Tx_data = shift_q & lsb;

endmodule

// File: tb/tb_tx_serializer.sv
// Directed bench for tx_serializer with a queue-based word scoreboard.
module tb_tx_serializer;
  import tx_serializer_pkg::*;

  logic       clk;
  logic       clr;
  logic       start;
  logic       Rx_ready;
  logic [7:0] rd_data;
  logic       rd_en;
  logic [1:0] adr;
  logic       Tx_vld;
  logic       Tx_data;
  logic       Tx_busy;
  logic       Tx_finish;

  logic [7:0] mem [4];
  logic [7:0] exp_q [$];
  int         vectors;
  int         miscompares;

  tx_serializer #(
    .DATA_W  (8),
    .N_WORDS (4)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .Rx_ready  (Rx_ready),
    .rd_data   (rd_data),
    .rd_en     (rd_en),
    .adr       (adr),
    .Tx_vld    (Tx_vld),
    .Tx_data   (Tx_data),
    .Tx_busy   (Tx_busy),
    .Tx_finish (Tx_finish)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: data valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[adr];
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(mem[i]);
  endtask

  task automatic wait_finish(input int exp_cycles);
    int n;
    n = 0;
    while (!Tx_finish && n < 200) begin
      tick();
      n++;
    end
    check("finish_latency", n, exp_cycles);
  endtask

  // Monitor: after each handshake, collect the next 8 serial bits and score the word.
  initial begin : monitor
    logic [7:0] got;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (Tx_vld) check("valid_data_low", Tx_data, 0);
      if (!clr && Tx_vld && Rx_ready) begin
        aborted = 1'b0;
        got     = '0;
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          if (clr) begin
            aborted = 1'b1;
            break;
          end
          got[i] = Tx_data;
          check("shift_vld_low", Tx_vld, 0);
        end
        if (!aborted) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", got, 32'hffff_ffff);
          end else begin
            check("serial_word", got, exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    vectors     = 0;
    miscompares = 0;
    mem[0] = 8'hA5;
    mem[1] = 8'h3C;
    mem[2] = 8'hFF;
    mem[3] = 8'h00;
    clr      = 1'b1;
    start    = 1'b0;
    Rx_ready = 1'b0;

    // Reset values, before any clock edge.
    #3;
    check("rst_rd_en", rd_en, 0);
    check("rst_adr", adr, 0);
    check("rst_vld", Tx_vld, 0);
    check("rst_data", Tx_data, 0);
    check("rst_busy", Tx_busy, 0);
    check("rst_finish", Tx_finish, 0);
    check("rst_sreg", dut.u_shift.sreg_q, 0);
    check("rst_cnt", dut.u_shift.cnt_q, 0);
    tick();
    tick();
    clr = 1'b0;
    repeat (3) tick();
    check("no_start_idle", Tx_busy, 0);

    // Full transfer with receiver always ready.
    Rx_ready = 1'b1;
    push_words(4);
    start = 1'b1;
    tick();                                   // j=0 READ
    start = 1'b0;
    check("w0_rd_en", rd_en, 1);
    check("w0_adr", adr, 0);
    check("w0_busy", Tx_busy, 1);
    check("w0_vld_early", Tx_vld, 0);
    tick();                                   // j=1 LATCH
    check("latch_rd_en", rd_en, 0);
    tick();                                   // j=2 VALID
    check("vld_latency", Tx_vld, 1);
    repeat (9) tick();                        // j=11 NEXT
    check("next_busy", Tx_busy, 1);
    check("next_vld", Tx_vld, 0);
    tick();                                   // j=12 READ word 1
    check("w1_rd_en", rd_en, 1);
    check("w1_adr", adr, 1);
    repeat (35) tick();                       // j=47 NEXT of word 3
    check("pre_finish", Tx_finish, 0);
    tick();                                   // j=48 DONE
    check("finish_48", Tx_finish, 1);
    check("done_busy", Tx_busy, 0);
    check("done_adr", adr, 3);
    repeat (3) tick();
    check("finish_held", Tx_finish, 1);

    // Restart from DONE, stall in VALID, disturb inputs during SHIFT.
    Rx_ready = 1'b0;
    push_words(4);
    start = 1'b1;
    tick();                                   // j=0
    start = 1'b0;
    check("restart_finish", Tx_finish, 0);
    check("restart_adr", adr, 0);
    check("restart_busy", Tx_busy, 1);
    tick();
    tick();                                   // j=2 VALID
    for (int k = 0; k < 5; k++) begin
      check("stall_vld", Tx_vld, 1);
      check("stall_sreg", dut.u_shift.sreg_q, 8'hA5);
      tick();
    end
    check("stall_vld6", Tx_vld, 1);           // j=7, sixth VALID cycle
    Rx_ready = 1'b1;
    tick();                                   // j=8 SHIFT
    check("shift_entry_vld", Tx_vld, 0);
    check("shift_entry_sreg", dut.u_shift.sreg_q, 8'hA5);
    start    = 1'b1;
    Rx_ready = 1'b0;
    tick();                                   // j=9
    start    = 1'b0;
    Rx_ready = 1'b1;
    tick();                                   // j=10
    Rx_ready = 1'b0;
    tick();                                   // j=11
    Rx_ready = 1'b1;
    repeat (5) tick();                        // j=16 NEXT
    check("stall_next_busy", Tx_busy, 1);
    tick();                                   // j=17 READ word 1
    check("start_ignored_adr", adr, 1);
    check("start_ignored_rd", rd_en, 1);
    wait_finish(36);

    // Reset in the middle of word 2, bit 4.
    push_words(2);
    start = 1'b1;
    tick();                                   // j=0
    start = 1'b0;
    check("w2run_adr0", adr, 0);
    repeat (31) tick();                       // j=31
    check("bit4_word2", Tx_data, 1);
    check("bit4_adr", adr, 2);
    #1 clr = 1'b1;
    #1;
    check("clr_busy", Tx_busy, 0);
    check("clr_vld", Tx_vld, 0);
    check("clr_data", Tx_data, 0);
    check("clr_rd_en", rd_en, 0);
    check("clr_adr", adr, 0);
    check("clr_state", dut.state_q, StIdle);
    @(negedge clk);
    #1 clr = 1'b0;
    repeat (4) tick();
    check("post_clr_idle", Tx_busy, 0);
    check("post_clr_finish", Tx_finish, 0);
    push_words(4);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("resend_adr", adr, 0);
    check("resend_rd_en", rd_en, 1);
    wait_finish(48);

    repeat (3) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
